nat_to_bitrev_reorder: RTL and testbench

- Ping-pong reorder buffer in front of a DIT FFT core.
- Accepts frames of N complex samples in natural order and emits each frame in bit-reversed order.
- Counterpart of the existing bit-reversed-to-natural output reorder.
- Unlike that block, both sides carry flow control: input backpressure and output stall, so it can sit between stalling stream sources and the FFT.

---
 rtl/fft_reorder_pkg.sv | 32 +++
 rtl/nat_to_bitrev_reorder_if.sv | 25 ++
 rtl/reorder_bank_ram.sv | 23 ++
 rtl/nat_to_bitrev_reorder.sv | 130 +++++++++++++
 tb/tb_nat_to_bitrev_reorder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared helpers for the FFT reorder buffers: index bit reversal and a
// constant-foldable ceil(log2) used to validate parameter pairs.
package fft_reorder_pkg;

    localparam int unsigned MaxBits = 16;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Reverses the low `bits` bits of idx; callers truncate to their own width.
    function automatic logic [MaxBits-1:0] bit_reverse(input logic [MaxBits-1:0] idx,
                                                       input int unsigned bits);
        logic [MaxBits-1:0] src;
        logic [MaxBits-1:0] rev;
        src = idx;
        rev = '0;
        for (int unsigned k = 0; k < MaxBits; k++) begin
            if (k < bits) begin
                rev = {rev[MaxBits-2:0], src[0]};
                src = src >> 1;
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/nat_to_bitrev_reorder_if.sv
// Stream bundle for the natural-to-bit-reversed reorder: sample input with
// backpressure and reordered output with stall.
interface nat_to_bitrev_reorder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             di_en;
    logic             di_rdy;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic             do_rdy;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;

    modport slave (
        input  di_en, di_re, di_im, do_rdy,
        output di_rdy, do_en, do_re, do_im, do_last
    );

    modport master (
        output di_en, di_re, di_im, do_rdy,
        input  di_rdy, do_en, do_re, do_im, do_last
    );
endinterface

// File: rtl/reorder_bank_ram.sv
// One reorder bank: synchronous write port, asynchronous read port.
module reorder_bank_ram #(
    parameter int unsigned Depth = 128,
    parameter int unsigned AddrW = 7,
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);
    logic [DataW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/nat_to_bitrev_reorder.sv
// Ping-pong buffer: frames written in natural order, read out bit-reversed,
// with input backpressure and a stallable output register.
module nat_to_bitrev_reorder
    import fft_reorder_pkg::*;
#(
    parameter int unsigned N     = 128,
    parameter int unsigned BITS  = 7,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    nat_to_bitrev_reorder_if.slave bus
);
    localparam int unsigned     DataW   = 2 * WIDTH;
    localparam int unsigned     BitsChk = clog2(N);
    localparam logic [BITS-1:0] LastIdx = BITS'(N - 1);

    if (N < 4 || BITS != BitsChk || (1 << BITS) != N) begin : g_bad_params
        $error("nat_to_bitrev_reorder: N must be a power of 2 >= 4 and BITS == log2(N)");
    end

    logic [1:0]       bank_full_q, bank_full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [BITS-1:0]  wr_cnt_q, wr_cnt_d;
    logic [BITS-1:0]  rd_cnt_q, rd_cnt_d;
    logic             do_en_q, do_en_d;
    logic             do_last_q, do_last_d;
    logic [WIDTH-1:0] do_re_q, do_re_d;
    logic [WIDTH-1:0] do_im_q, do_im_d;

    logic             di_rdy;
    logic             accept;
    logic             load;
    logic             issue;
    logic [1:0]       we;
    logic [BITS-1:0]  rd_addr;
    logic [DataW-1:0] wdata;
    logic [DataW-1:0] rdata [2];

    assign di_rdy  = ~bank_full_q[wr_sel_q];
    assign accept  = bus.di_en & di_rdy;
    assign load    = ~do_en_q | bus.do_rdy;
    assign issue   = load & bank_full_q[rd_sel_q];
    assign rd_addr = BITS'(bit_reverse(MaxBits'(rd_cnt_q), BITS));
    assign wdata   = {bus.di_re, bus.di_im};
    assign we[0]   = accept & ~wr_sel_q;
    assign we[1]   = accept & wr_sel_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank_ram #(
            .Depth (N),
            .AddrW (BITS),
            .DataW (DataW)
        ) u_ram (
            .clk_i   (clock),
            .we_i    (we[b]),
            .waddr_i (wr_cnt_q),
            .wdata_i (wdata),
            .raddr_i (rd_addr),
            .rdata_o (rdata[b])
        );
    end

    always_comb begin
        bank_full_d = bank_full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        do_en_d     = do_en_q;
        do_last_d   = do_last_q;
        do_re_d     = do_re_q;
        do_im_d     = do_im_q;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LastIdx) begin
                bank_full_d[wr_sel_q] = 1'b1;
                wr_sel_d              = ~wr_sel_q;
            end
        end

        // Writer and reader never touch the same flag on one edge: the
        // writer only fills an empty bank, the reader only drains a full one.
        if (issue) begin
            {do_re_d, do_im_d} = rdata[rd_sel_q];
            do_en_d            = 1'b1;
            do_last_d          = (rd_cnt_q == LastIdx);
            rd_cnt_d           = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LastIdx) begin
                bank_full_d[rd_sel_q] = 1'b0;
                rd_sel_d              = ~rd_sel_q;
            end
        end else if (load) begin
            do_en_d   = 1'b0;
            do_last_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_full_q <= 2'b00;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            do_en_q     <= 1'b0;
            do_last_q   <= 1'b0;
            do_re_q     <= '0;
            do_im_q     <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            do_en_q     <= do_en_d;
            do_last_q   <= do_last_d;
            do_re_q     <= do_re_d;
            do_im_q     <= do_im_d;
        end
    end

    assign bus.di_rdy  = di_rdy;
    assign bus.do_en   = do_en_q;
    assign bus.do_last = do_last_q;
    assign bus.do_re   = do_re_q;
    assign bus.do_im   = do_im_q;
endmodule

// File: tb/tb_nat_to_bitrev_reorder.sv
// Directed bench for nat_to_bitrev_reorder at N=8: ordering, latency,
// back-to-back frames, output stall, sparse handshakes and mid-frame reset.
module tb_nat_to_bitrev_reorder;
    localparam int unsigned N     = 8;
    localparam int unsigned BITS  = 3;
    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             last;
    } samp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    nat_to_bitrev_reorder_if #(.WIDTH(WIDTH)) bus ();

    nat_to_bitrev_reorder #(
        .N     (N),
        .BITS  (BITS),
        .WIDTH (WIDTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc, n_cons, cyc;
    int first_acc_cyc, last_acc_cyc, first_cons_cyc, last_cons_cyc;
    logic [WIDTH-1:0] frame_re [N];
    logic [WIDTH-1:0] frame_im [N];
    samp_t            exp_q [$];
    logic [WIDTH-1:0] got_re [$];
    logic             got_last [$];
    int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int rst_ord [8] = '{50, 54, 52, 56, 51, 55, 53, 57};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int brev(input int i);
        logic [2:0] v;
        v = i[2:0];
        return int'({v[0], v[1], v[2]});
    endfunction

    task automatic clear_model();
        n_acc = 0;
        n_cons = 0;
        cyc = 0;
        first_acc_cyc = -1;
        last_acc_cyc = -1;
        first_cons_cyc = -1;
        last_cons_cyc = -1;
        exp_q.delete();
        got_re.delete();
        got_last.delete();
    endtask

    // One clock: record handshakes before the edge, check holds after it.
    task automatic tick();
        logic acc, cons, hold, olast;
        logic [WIDTH-1:0] ore, oim;
        samp_t e;
        acc   = bus.di_en && bus.di_rdy;
        cons  = bus.do_en && bus.do_rdy;
        hold  = bus.do_en && !bus.do_rdy;
        ore   = bus.do_re;
        oim   = bus.do_im;
        olast = bus.do_last;
        if (acc) begin
            frame_re[n_acc % N] = bus.di_re;
            frame_im[n_acc % N] = bus.di_im;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            if (n_acc % N == N - 1) begin
                for (int i = 0; i < N; i++) begin
                    exp_q.push_back('{re: frame_re[brev(i)], im: frame_im[brev(i)],
                                      last: (i == N - 1)});
                end
            end
            n_acc++;
        end
        if (cons) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_re", ore, e.re);
                check("sb_im", oim, e.im);
                check("sb_last", olast, e.last);
            end
            got_re.push_back(ore);
            got_last.push_back(olast);
            if (first_cons_cyc < 0) first_cons_cyc = cyc;
            last_cons_cyc = cyc;
            n_cons++;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (hold) begin
            check("hold_en", bus.do_en, 1);
            check("hold_re", bus.do_re, ore);
            check("hold_im", bus.do_im, oim);
            check("hold_last", bus.do_last, olast);
        end
    endtask

    // rmode/emode: 0 = always high, 1 = always low, 2 = random 50%.
    task automatic run(input int nin, input int ncons, input int base, input int rmode,
                       input int emode, input int budget);
        for (int k = 0; k < budget && (n_acc < nin || n_cons < ncons); k++) begin
            bus.di_en  = (n_acc < nin) && (emode == 0 || $urandom_range(0, 1) == 1);
            bus.di_re  = WIDTH'(base + n_acc);
            bus.di_im  = WIDTH'(base + 100 + n_acc);
            bus.do_rdy = (rmode == 0) || (rmode == 2 && $urandom_range(0, 1) == 1);
            tick();
        end
        bus.di_en = 1'b0;
    endtask

    // Asynchronous assert mid-cycle, check outputs before any edge, release mid-cycle.
    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        check("rst_do_en", bus.do_en, 0);
        check("rst_do_last", bus.do_last, 0);
        check("rst_do_re", bus.do_re, 0);
        check("rst_do_im", bus.do_im, 0);
        check("rst_di_rdy", bus.di_rdy, 1);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        clear_model();
    endtask

    initial begin
        bus.di_en  = 1'b0;
        bus.di_re  = '0;
        bus.di_im  = '0;
        bus.do_rdy = 1'b0;
        clear_model();
        @(posedge clock);
        #1;

        // Basic reorder and first-output latency
        do_reset();
        run(8, 8, 0, 0, 0, 100);
        check("basic_cnt", got_re.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("basic_re", got_re[k], ord[k]);
            check("basic_last", got_last[k], (k == 7));
        end
        check("latency", first_cons_cyc - last_acc_cyc, 2);

        // Three frames back-to-back; also exercises the shared-edge bank handover
        do_reset();
        run(24, 24, 0, 0, 0, 200);
        check("b2b_cnt", n_cons, 24);
        check("b2b_out_gapless", last_cons_cyc - first_cons_cyc, 23);
        check("b2b_in_gapless", last_acc_cyc - first_acc_cyc, 23);
        for (int k = 8; k < 16; k++) check("b2b_frame2", got_re[k], ord[k - 8] + 8);
        check("b2b_idle_en", bus.do_en, 0);
        check("b2b_idle_rdy", bus.di_rdy, 1);

        // Output stall: two frames fill both banks, then drain
        do_reset();
        run(40, 0, 0, 1, 0, 30);
        check("stall_acc", n_acc, 16);
        check("stall_di_rdy", bus.di_rdy, 0);
        check("stall_do_en", bus.do_en, 1);
        check("stall_do_re", bus.do_re, 0);
        run(16, 16, 0, 0, 0, 200);
        check("stall_drain_cnt", n_cons, 16);
        for (int k = 0; k < 8; k++) begin
            check("stall_f0", got_re[k], ord[k]);
            check("stall_f1", got_re[k + 8], ord[k] + 8);
        end
        check("stall_rdy_back", bus.di_rdy, 1);

        // Sparse random handshakes over 10 frames
        do_reset();
        run(80, 80, 0, 2, 2, 3000);
        check("sparse_cnt", n_cons, 80);
        check("sparse_left", exp_q.size(), 0);

        // Reset with a frame in the output register and a partial frame behind it
        do_reset();
        run(13, 0, 30, 1, 0, 40);
        check("pre_rst_acc", n_acc, 13);
        check("pre_rst_re", bus.do_re, 30);
        do_reset();
        run(8, 8, 50, 0, 0, 100);
        check("post_rst_cnt", got_re.size(), 8);
        for (int k = 0; k < 8; k++) check("post_rst_re", got_re[k], rst_ord[k]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
